// File: rtl/skew_tile_sequencer.sv
// Load/drain sequencer for one skew buffer per operand tile.
// Optional perf counters (stall_cycles, tiles_done) under SKEW_TILE_SEQ_PERF_EN.

module skew_tile_lane #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] in_elem,
  output logic [DATA_WIDTH-1:0] out_elem
);
  // Forward the element only while loading so the buffer bus stays quiet otherwise.
  assign out_elem = load ? in_elem : '0;
endmodule

module skew_tile_sequencer #(
  parameter int ARRAY_SIZE = 8,
  parameter int DATA_WIDTH = 8,
  parameter int DRAIN_LEN  = 2*ARRAY_SIZE-1
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  start,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  input  logic [ARRAY_SIZE-1:0][DATA_WIDTH-1:0] in_data,
  output logic                                  buf_write,
  output logic [$clog2(ARRAY_SIZE)-1:0]         buf_row_ptr,
  output logic [ARRAY_SIZE-1:0][DATA_WIDTH-1:0] buf_data,
  output logic                                  buf_enable,
  input  logic                                  array_ready,
  output logic                                  array_valid,
  output logic                                  busy,
  output logic                                  done
`ifdef SKEW_TILE_SEQ_PERF_EN
  ,
  output logic [15:0]                           stall_cycles,
  output logic [15:0]                           tiles_done
`endif
);

  localparam int PTR_W = $clog2(ARRAY_SIZE);
  localparam int CNT_W = $clog2(DRAIN_LEN);
  localparam logic [CNT_W-1:0] LAST_ROW  = CNT_W'(ARRAY_SIZE-1);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(DRAIN_LEN-1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] load_cnt, load_cnt_nxt;
  logic [CNT_W-1:0] drain_cnt, drain_cnt_nxt;
  logic             load;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      load_cnt  <= '0;
      drain_cnt <= '0;
    end else begin
      state     <= state_nxt;
      load_cnt  <= load_cnt_nxt;
      drain_cnt <= drain_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    load_cnt_nxt  = load_cnt;
    drain_cnt_nxt = drain_cnt;
    load          = 1'b0;
    in_ready      = 1'b0;
    buf_write     = 1'b0;
    buf_enable    = 1'b0;
    busy          = 1'b0;
    done          = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start) state_nxt = S_LOAD;
      end
      S_LOAD: begin
        busy      = 1'b1;
        load      = 1'b1;
        in_ready  = 1'b1;
        buf_write = in_valid;
        if (in_valid) begin
          if (load_cnt == LAST_ROW) begin
            state_nxt    = S_DRAIN;
            load_cnt_nxt = '0;
          end else begin
            load_cnt_nxt = load_cnt + CNT_W'(1);
          end
        end
      end
      // A stalled beat leaves both the buffer and the counter untouched.
      S_DRAIN: begin
        busy       = 1'b1;
        buf_enable = array_ready;
        if (array_ready) begin
          if (drain_cnt == LAST_BEAT) begin
            state_nxt     = S_DONE;
            drain_cnt_nxt = '0;
          end else begin
            drain_cnt_nxt = drain_cnt + CNT_W'(1);
          end
        end
      end
      S_DONE: begin
        busy          = 1'b1;
        done          = 1'b1;
        load_cnt_nxt  = '0;
        drain_cnt_nxt = '0;
        state_nxt     = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign array_valid = buf_enable;
  assign buf_row_ptr = load ? PTR_W'(load_cnt) : '0;

  for (genvar g = 0; g < ARRAY_SIZE; g++) begin : g_lane
    skew_tile_lane #(.DATA_WIDTH(DATA_WIDTH)) u_lane (
      .load     (load),
      .in_elem  (in_data[g]),
      .out_elem (buf_data[g])
    );
  end

`ifdef SKEW_TILE_SEQ_PERF_EN
  // Both counters span tiles; only rst clears them.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles <= '0;
      tiles_done   <= '0;
    end else begin
      if (state == S_DRAIN && !array_ready && stall_cycles != 16'hFFFF)
        stall_cycles <= stall_cycles + 16'd1;
      if (done)
        tiles_done <= tiles_done + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_skew_tile_sequencer.sv
// Randomized scoreboard bench for skew_tile_sequencer (ARRAY_SIZE=4).
module tb_skew_tile_sequencer;
  localparam int AS = 4;
  localparam int DW = 8;
  localparam int DL = 2*AS-1;

  logic clk = 1'b0;
  logic rst, start, in_valid, in_ready, buf_write, buf_enable;
  logic array_ready, array_valid, busy, done;
  logic [AS-1:0][DW-1:0] in_data, buf_data;
  logic [$clog2(AS)-1:0] buf_row_ptr;
`ifdef SKEW_TILE_SEQ_PERF_EN
  logic [15:0] stall_cycles, tiles_done;
`endif

  skew_tile_sequencer #(.ARRAY_SIZE(AS), .DATA_WIDTH(DW), .DRAIN_LEN(DL)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .buf_write   (buf_write),
    .buf_row_ptr (buf_row_ptr),
    .buf_data    (buf_data),
    .buf_enable  (buf_enable),
    .array_ready (array_ready),
    .array_valid (array_valid),
    .busy        (busy),
    .done        (done)
`ifdef SKEW_TILE_SEQ_PERF_EN
    ,
    .stall_cycles(stall_cycles),
    .tiles_done  (tiles_done)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          row;
    logic [31:0] data;
  } wr_t;

  wr_t wr_q[$];
  int  done_q[$];
  int  n_chk = 0, n_fail = 0;
  int  n_done_seen = 0, n_tiles_exp = 0;
  int  stalls_m = 0, tiles_m = 0;
  bit  mon_en = 0, exp_load = 0, exp_drain = 0, exp_busy = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: compares the DUT against the phase flags and queues the driver maintains.
  initial begin
    int  en_cnt;
    wr_t w;
    en_cnt = 0;
    forever begin
      @(negedge clk);
      if (rst || !mon_en) begin
        en_cnt = 0;
      end else begin
        chk("in_ready", in_ready, exp_load);
        chk("busy", busy, exp_busy);
        chk("buf_write", buf_write, exp_load && in_valid);
        chk("buf_enable", buf_enable, exp_drain && array_ready);
        chk("array_valid", array_valid, buf_enable);
        if (!exp_load) chk("row_ptr_idle", buf_row_ptr, 0);
        if (buf_enable) en_cnt++;
        if (buf_write) begin
          if (wr_q.size() == 0) chk("write_unexpected", 1, 0);
          else begin
            w = wr_q.pop_front();
            chk("row_ptr", buf_row_ptr, w.row);
            chk("buf_data", buf_data, w.data);
          end
        end
        if (done) begin
          n_done_seen++;
          if (done_q.size() == 0) chk("done_unexpected", 1, 0);
          else chk("done_cycle", cyc, done_q.pop_front());
          chk("drain_beats", en_cnt, DL);
          chk("writes_left", wr_q.size(), 0);
          en_cnt = 0;
        end
      end
    end
  end

  task automatic wait_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic noise();
    in_valid    = $urandom_range(0, 1);
    array_ready = $urandom_range(0, 1);
    in_data     = $urandom;
  endtask

  task automatic check_idle();
    @(negedge clk);
    chk("idle_busy", busy, 0);
    chk("idle_in_ready", in_ready, 0);
    chk("idle_buf_write", buf_write, 0);
    chk("idle_buf_enable", buf_enable, 0);
    chk("idle_done", done, 0);
    chk("idle_row_ptr", buf_row_ptr, 0);
    chk("idle_buf_data", buf_data, 0);
  endtask

  // One tile: bub/stl mark bubble/stall cycles when rnd=0; abort_at>=0 resets after that many beats.
  task automatic run_tile(input bit rnd, input logic [31:0] bub, input logic [31:0] stl,
                          input int abort_at);
    int  s, n, lc, d, dc;
    bit  v, r;
    wr_t w;
    start = 1'b1;
    s = cyc;
    wait_cycle();
    exp_busy = 1; exp_load = 1;
    n = 0; lc = 0;
    while (n < AS) begin
      if (rnd) v = ($urandom_range(0, 3) != 0);
      else     v = !bub[lc];
      in_valid    = v;
      in_data     = $urandom;
      array_ready = $urandom_range(0, 1);
      start       = ($urandom_range(0, 3) == 0);
      if (v) begin
        w.row = n; w.data = in_data;
        wr_q.push_back(w);
        n++;
      end
      wait_cycle();
      lc++;
    end
    exp_load = 0; exp_drain = 1;
    d = 0; dc = 0;
    while (d < DL) begin
      if (abort_at >= 0 && d == abort_at) begin
        rst = 1; start = 0; in_valid = 0; array_ready = 0;
        wait_cycle();
        rst = 0;
        exp_drain = 0; exp_busy = 0;
        wr_q.delete();
        stalls_m = 0; tiles_m = 0;
        check_idle();
        return;
      end
      if (rnd) r = ($urandom_range(0, 2) != 0);
      else     r = !stl[dc];
      array_ready = r;
      in_valid    = $urandom_range(0, 1);
      in_data     = $urandom;
      start       = ($urandom_range(0, 3) == 0);
      if (r) d++;
      else   stalls_m++;
      wait_cycle();
      dc++;
    end
    exp_drain = 0;
    done_q.push_back(s + 1 + lc + dc);
    n_tiles_exp++; tiles_m++;
    start = $urandom_range(0, 1);
    noise();
    wait_cycle();
    exp_busy = 0;
    start = 0;
    noise();
  endtask

  initial begin
    rst = 1; start = 0; in_valid = 0; array_ready = 0; in_data = '0;
    repeat (3) wait_cycle();
    rst = 0;
    mon_en = 1;
    check_idle();

    run_tile(0, 32'h0, 32'h0, -1);         // no bubbles, no stalls
    wait_cycle();
    run_tile(0, 32'h6, 32'h0, -1);         // bubbles in LOAD cycles 2,3
    wait_cycle();
    run_tile(0, 32'h0, 32'h1C, -1);        // three stalls mid-drain
    wait_cycle();
    run_tile(0, 32'h0, 32'h0, 2);          // reset after two beats
    run_tile(0, 32'h0, 32'h0, -1);
    run_tile(0, 32'h0, 32'h0, -1);         // back-to-back tiles
    run_tile(0, 32'h0, 32'h0, -1);
    for (int t = 0; t < 30; t++) begin
      if ($urandom_range(0, 7) == 0) run_tile(1, 32'h0, 32'h0, $urandom_range(0, DL-1));
      else                          run_tile(1, 32'h0, 32'h0, -1);
      repeat ($urandom_range(0, 2)) begin
        noise();
        wait_cycle();
      end
    end
    in_valid = 0; array_ready = 0;
    repeat (4) wait_cycle();
    chk("pending_done", done_q.size(), 0);
    chk("pending_writes", wr_q.size(), 0);
    chk("tile_count", n_done_seen, n_tiles_exp);
`ifdef SKEW_TILE_SEQ_PERF_EN
    chk("stall_cycles", stall_cycles, stalls_m);
    chk("tiles_done", tiles_done, tiles_m);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
